mem_arbiter: RTL

Two-port arbiter that shares the single-port unified instruction/data memory of the multi-cycle processor between the CPU and a secondary master (program loader / DMA). It grants at most one requester per cycle, drives the memory's write-enable, address and write-data, and returns registered read data to the granted requester. Round-robin fairness is used, with an optional bus lock for atomic read-modify-write sequences.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_rr2.sv | 20 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned PortM0 = 0;
  localparam int unsigned PortM1 = 1;

  localparam int unsigned LockMaxDefault = 8;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: on a tie the port not served last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    // last = 1 means m1 was served most recently, so m0 takes a tie
    if (req[PortM0] && (!req[PortM1] || last)) begin
      gnt[PortM0] = 1'b1;
    end else if (req[PortM1]) begin
      gnt[PortM1] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / loader arbiter for the single-port unified memory with round-robin fairness.
// Define MEM_ARB_LOCK_EN to enable bus locking (OWN0/OWN1 states, bounded lock counter).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LockMaxDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  rr_gnt;
  logic [1:0]  gnt;
  logic [1:0]  gnt_m;
  logic        last_q, last_d;
  logic [1:0]  rvalid_q;
  logic [31:0] rdata0_q, rdata1_q;

  assign req = {m1_req, m0_req};
  assign we  = {m1_we, m0_we};

  arb_rr2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      lock;
  logic [1:0]      own;
  logic            sat;
  logic            own_hold;

  assign lock = {m1_lock, m0_lock};
  assign own  = {state_q == OWN1, state_q == OWN0};
  assign sat  = (cnt_q == CntW'(LOCK_MAX));
  // Owner keeps the bus unless it lets go or has used up its budget while the other port waits
  assign own_hold = |(own & req & lock) && !(sat && |(~own & req));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 2'b00;
    if (own_hold) begin
      gnt   = own;
      cnt_d = sat ? cnt_q : cnt_q + CntW'(1);
    end else begin
      gnt = rr_gnt;
      if (|(rr_gnt & lock)) begin
        state_d = rr_gnt[PortM1] ? OWN1 : OWN0;
        cnt_d   = CntW'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = m0_lock ^ m1_lock;
  assign gnt         = rr_gnt;
`endif

  // Reset masks the bus immediately so no write can commit on a reset edge
  assign gnt_m  = gnt & {2{~reset}};
  assign m0_gnt = gnt_m[PortM0];
  assign m1_gnt = gnt_m[PortM1];
  assign mem_we = |(gnt_m & we);
  assign mem_a  = gnt_m[PortM1] ? m1_addr  : (gnt_m[PortM0] ? m0_addr  : 32'd0);
  assign mem_wd = gnt_m[PortM1] ? m1_wdata : (gnt_m[PortM0] ? m0_wdata : 32'd0);

  assign last_d = gnt[PortM1] ? 1'b1 : (gnt[PortM0] ? 1'b0 : last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= gnt & ~we;
      if (gnt[PortM0] && !m0_we) begin
        rdata0_q <= mem_rd;
      end
      if (gnt[PortM1] && !m1_we) begin
        rdata1_q <= mem_rd;
      end
    end
  end

  assign m0_rvalid = rvalid_q[PortM0];
  assign m1_rvalid = rvalid_q[PortM1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule
